// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit:
// op encodings, FSM states and default latencies.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    localparam int CNT_W           = 5;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result for mult/multu/div/divu.
// Division by zero returns the current hi/lo unchanged.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic        div_zero;

    assign prod_s = $signed({{32{rs_data[31]}}, rs_data})
                  * $signed({{32{rt_data[31]}}, rt_data});
    assign prod_u = {32'b0, rs_data} * {32'b0, rt_data};

    // Signed divide on magnitudes; 0x80000000/-1 falls out as 0x80000000 r 0
    assign neg_a    = rs_data[31];
    assign neg_b    = rt_data[31];
    assign abs_a    = neg_a ? -rs_data : rs_data;
    assign abs_b    = neg_b ? -rt_data : rt_data;
    assign div_zero = (rt_data == 32'd0);
    assign q_mag    = div_zero ? 32'd0 : abs_a / abs_b;
    assign r_mag    = div_zero ? 32'd0 : abs_a % abs_b;

    always_comb begin
        res = {hi, lo};
        unique case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV: begin
                if (!div_zero) begin
                    res = {neg_a ? -r_mag : r_mag,
                           (neg_a ^ neg_b) ? -q_mag : q_mag};
                end
            end
            MDU_DIVU: begin
                if (!div_zero) begin
                    res = {rs_data % rt_data, rs_data / rt_data};
                end
            end
            default: res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// Result is computed at issue and committed after a fixed latency.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state;
    mdu_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic [63:0]      res;
    logic             is_mul;
    logic             is_div;
    logic             issue;
    logic             commit;
    logic             wr_hi;
    logic             wr_lo;

    mdu_arith u_arith (
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi      (hi),
        .lo      (lo),
        .res     (res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state <= state_next;
            if (issue) begin
                pend_hi <= res[63:32];
                pend_lo <= res[31:0];
                cnt     <= is_mul ? MULT_LAT : DIV_LAT;
            end else if (state == RUN) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            if (wr_hi) hi <= rs_data;
            if (wr_lo) lo <= rs_data;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (issue) state_next = RUN;
            RUN:     if (commit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ops arriving during RUN are dropped; upstream holds them on busy
    always_comb begin
        is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
        is_div = (op == MDU_DIV) || (op == MDU_DIVU);
        issue  = (state == IDLE) && (is_mul || is_div);
        commit = (state == RUN) && (cnt == CNT_W'(1));
        wr_hi  = (state == IDLE) && (op == MDU_MTHI);
        wr_lo  = (state == IDLE) && (op == MDU_MTLO);
        busy   = (state == RUN);
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases then
// random ops against a cycle-level arithmetic reference model.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errs   = 0;
    int checks = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_phi;
    logic [31:0] m_plo;
    int          m_left;

    mdu_unit #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [2:0] o,
        input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] h, input logic [31:0] l);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        longint q;
        longint r;
        longint unsigned p;
        if (o == MDU_MULT) begin
            q = sa * sb;
            return q;
        end else if (o == MDU_MULTU) begin
            p = ua * ub;
            return p;
        end else if (b == 0) begin
            return {h, l};
        end else if (o == MDU_DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        p = ua / ub;
        r = longint'(ua % ub);
        return {r[31:0], p[31:0]};
    endfunction

    task automatic model_step(input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] b);
        logic [63:0] r;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (o inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}) begin
            r      = ref_res(o, a, b, m_hi, m_lo);
            m_phi  = r[63:32];
            m_plo  = r[31:0];
            m_left = (o inside {MDU_MULT, MDU_MULTU}) ? MC : DC;
        end else if (o == MDU_MTHI) begin
            m_hi = a;
        end else if (o == MDU_MTLO) begin
            m_lo = a;
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
    endtask

    task automatic cyc(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
        op = o; rs_data = a; rt_data = b;
        @(posedge clk);
        model_step(o, a, b);
        #1;
        check("busy", {31'b0, busy}, {31'b0, m_left > 0});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eh,
                          input logic [31:0] el);
        int n = 0;
        cyc(o, a, b);
        while (busy && n < 40) begin
            cyc(MDU_NONE, 0, 0);
            n++;
        end
        check({tag, "_len"}, n, lat);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [6] = '{32'h0, 32'h1, 32'hFFFFFFFF,
                               32'h80000000, 32'h7FFFFFFF, 32'h7};
        if ($urandom_range(3) == 0) return c[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        int n;
        reset = 1'b0; op = MDU_NONE; rs_data = 0; rt_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b1;

        run_op("mult", MDU_MULT, 32'hFFFFFFFE, 32'd3, MC,
               32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MC,
               32'hFFFFFFFE, 32'h00000001);
        run_op("div", MDU_DIV, 32'hFFFFFFF9, 32'd2, DC,
               32'hFFFFFFFF, 32'hFFFFFFFD);

        cyc(MDU_MTHI, 32'h1234, 0);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        cyc(MDU_MTLO, 32'h5678, 0);
        check("mtlo_busy", {31'b0, busy}, 32'd0);
        run_op("divz", MDU_DIVU, 32'd9, 32'd0, DC, 32'h1234, 32'h5678);
        run_op("ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, DC,
               32'h0, 32'h80000000);

        // Ops presented while busy must be dropped
        cyc(MDU_DIV, 32'd100, 32'd7);
        cyc(MDU_MULT, 32'd2, 32'd2);
        cyc(MDU_MTHI, 32'hAA, 0);
        n = 3;
        while (busy && n < 40) begin
            cyc(MDU_NONE, 0, 0);
            n++;
        end
        check("ign_len", n, DC + 1);
        check("ign_hi", hi, 32'd2);
        check("ign_lo", lo, 32'd14);

        // Asynchronous abort in the middle of a mult
        cyc(MDU_MULT, 32'd3, 32'd4);
        repeat (2) cyc(MDU_NONE, 0, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (8) cyc(MDU_NONE, 0, 0);
        check("abort_keep_hi", hi, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            cyc(3'($urandom_range(7)), pick(), pick());
        end
        for (int i = 0; i < DC + 1; i++) cyc(MDU_NONE, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
